ttt_turn_sequencer: RTL

//  Owns the 3x3 tic-tac-toe board and hands out turns to two move sources (P0 = X, P1 = O).

---
 rtl/ttt_pkg.sv | 33 +++
 rtl/ttt_win_check.sv | 38 +++
 rtl/ttt_turn_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ttt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ttt_pkg
// Purpose  : Shared types and constants for the tic-tac-toe turn sequencer:
//            FSM state encoding, winner codes, win-line masks, cell range.
// Revision : 1.0 - initial release
// ============================================================================
package ttt_pkg;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_P0   = 2'b01;
  localparam logic [1:0] W_P1   = 2'b10;
  localparam logic [1:0] W_DRAW = 2'b11;

  localparam int NUM_LINES = 8;

  // Ordered by reporting priority: rows, columns, main diagonal, anti-diagonal.
  localparam logic [8:0] WIN_LINES [0:7] = '{
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  localparam logic [3:0] CELL_MAX = 4'd8;

endpackage
`default_nettype wire

// File: rtl/ttt_win_check.sv
`default_nettype none
// ============================================================================
// Module   : ttt_win_check
// Purpose  : Combinational win detector. Reports whether the given player
//            owns a complete line and which line (first in priority order).
// Revision : 1.0 - initial release
// ============================================================================
module ttt_win_check
  import ttt_pkg::*;
(
  input  logic [8:0] grid_active,
  input  logic [8:0] grid_mark,
  input  logic       player,
  output logic       win,
  output logic [8:0] line_mask
);

  logic [8:0] owned;

  // Cells held by the player under test.
  always_comb begin
    owned = grid_active & (player ? grid_mark : ~grid_mark);
  end

  // Scan from lowest priority upward so the earliest matching line is kept.
  always_comb begin
    win       = 1'b0;
    line_mask = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if ((owned & WIN_LINES[i]) == WIN_LINES[i]) begin
        win       = 1'b1;
        line_mask = WIN_LINES[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ttt_turn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ttt_turn_sequencer
// Purpose  : Owns the 3x3 board, grants turns to P0 (X) and P1 (O), rejects
//            illegal moves, detects win/draw and ends or alternates the game.
//            Optional turn timeout enabled by defining TTT_TURN_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ttt_turn_sequencer
  import ttt_pkg::*;
#(
  parameter bit          START_PLAYER   = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       p0_valid,
  input  logic [3:0] p0_cell,
  output logic       p0_ready,
  input  logic       p1_valid,
  input  logic [3:0] p1_cell,
  output logic       p1_ready,
  output logic [8:0] grid_active,
  output logic [8:0] grid_mark,
  output logic       turn,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [8:0] win_line,
  output logic       move_reject,
  output logic       timeout
);

  state_t     state_q, state_d;
  logic [8:0] grid_active_q, grid_active_d;
  logic [8:0] grid_mark_q, grid_mark_d;
  logic [8:0] win_line_q, win_line_d;
  logic [1:0] winner_q, winner_d;
  logic       turn_q, turn_d;
  logic       move_reject_q, move_reject_d;
  logic       timeout_q, timeout_d;

  logic       accept;
  logic       legal;
  logic [3:0] sel_cell;
  logic [8:0] cell_onehot;
  logic       mover_wins;
  logic [8:0] mover_line;
  logic       board_full;
  logic       timeout_hit;

  // Select the current mover's request and qualify the target cell.
  always_comb begin
    sel_cell    = turn_q ? p1_cell : p0_cell;
    accept      = (state_q == ST_PLAY) && (turn_q ? p1_valid : p0_valid);
    cell_onehot = 9'd1 << sel_cell;
    legal       = (sel_cell <= CELL_MAX) && ((grid_active_q & cell_onehot) == 9'd0);
    board_full  = &grid_active_q;
  end

  ttt_win_check u_win_check (
    .grid_active (grid_active_q),
    .grid_mark   (grid_mark_q),
    .player      (turn_q),
    .win         (mover_wins),
    .line_mask   (mover_line)
  );

`ifdef TTT_TURN_TIMEOUT_EN
  localparam logic [26:0] TIMEOUT_LAST = 27'(TIMEOUT_CYCLES - 1);

  logic [26:0] tmo_cnt_q, tmo_cnt_d;

  // Idle counter: runs only while waiting in PLAY, cleared by any accept.
  always_comb begin
    timeout_hit = (state_q == ST_PLAY) && !new_game && !accept &&
                  (tmo_cnt_q == TIMEOUT_LAST);
    tmo_cnt_d   = '0;
    if (!new_game && (state_q == ST_PLAY) && !accept && !timeout_hit) begin
      tmo_cnt_d = tmo_cnt_q + 27'd1;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Next-state: a legal move goes to CHECK, CHECK resolves to PLAY or DONE.
  always_comb begin
    state_d = state_q;
    if (new_game) begin
      state_d = ST_PLAY;
    end else begin
      case (state_q)
        ST_PLAY:  if (accept && legal) state_d = ST_CHECK;
        ST_CHECK: state_d = (mover_wins || board_full) ? ST_DONE : ST_PLAY;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_PLAY;
      endcase
    end
  end

  // Board, turn and result updates.
  always_comb begin
    grid_active_d = grid_active_q;
    grid_mark_d   = grid_mark_q;
    win_line_d    = win_line_q;
    winner_d      = winner_q;
    turn_d        = turn_q;
    move_reject_d = 1'b0;
    timeout_d     = 1'b0;
    if (new_game) begin
      grid_active_d = '0;
      grid_mark_d   = '0;
      win_line_d    = '0;
      winner_d      = W_NONE;
      turn_d        = START_PLAYER;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (accept) begin
            if (legal) begin
              grid_active_d = grid_active_q | cell_onehot;
              grid_mark_d   = grid_mark_q | (turn_q ? cell_onehot : 9'd0);
            end else begin
              move_reject_d = 1'b1;
            end
          end else if (timeout_hit) begin
            timeout_d = 1'b1;
            turn_d    = ~turn_q;
          end
        end
        ST_CHECK: begin
          if (mover_wins) begin
            winner_d   = turn_q ? W_P1 : W_P0;
            win_line_d = mover_line;
          end else if (board_full) begin
            winner_d = W_DRAW;
          end else begin
            turn_d = ~turn_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_PLAY;
      grid_active_q <= '0;
      grid_mark_q   <= '0;
      win_line_q    <= '0;
      winner_q      <= W_NONE;
      turn_q        <= START_PLAYER;
      move_reject_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grid_active_q <= grid_active_d;
      grid_mark_q   <= grid_mark_d;
      win_line_q    <= win_line_d;
      winner_q      <= winner_d;
      turn_q        <= turn_d;
      move_reject_q <= move_reject_d;
      timeout_q     <= timeout_d;
    end
  end

  // Outputs: grant only the player whose turn it is, and only in PLAY.
  always_comb begin
    p0_ready    = (state_q == ST_PLAY) && !turn_q;
    p1_ready    = (state_q == ST_PLAY) && turn_q;
    game_over   = (state_q == ST_DONE);
    grid_active = grid_active_q;
    grid_mark   = grid_mark_q;
    turn        = turn_q;
    winner      = winner_q;
    win_line    = win_line_q;
    move_reject = move_reject_q;
    timeout     = timeout_q;
  end

endmodule
`default_nettype wire
